score_keeper: RTL and testbench

Two-player score accumulator for one round of the rhythm game. It sits between the per-player hit judges and the `winner` comparator. It counts notes in a round, converts each player's per-note hit/miss into a saturating 5-bit score with a streak bonus, and presents `result1`/`result2` plus a round-complete flag that `winner` consumes.

---
 rtl/score_keeper.sv | 191 +++++++++++++++++++
 tb/tb_score_keeper.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//
// Two-player score accumulator for one round of the rhythm game. It counts the
// notes judged in a round. It turns each player's per-note hit/miss into a
// saturating 5-bit score with a streak bonus. It flags round completion to the
// downstream winner comparator.
//
// Scoring rules per player, applied on every judged note (note_tick in PLAY):
//   hit,  streak == 3 : +2 (one point plus bonus), streak -> 0
//   hit,  streak <  3 : +1, streak -> streak + 1
//   miss              : +0, streak -> 0
//   The score is clamped at MAX_SCORE and never wraps.
//
// Parameters:
//   ROUND_NOTES  notes per round, legal range 1..31
//   MAX_SCORE    saturation ceiling, must be <= 31
//
// Ports:
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous active-high reset, clears all state
//   start       in   1  round-start pulse (honoured in IDLE and DONE)
//   note_tick   in   1  one-cycle pulse closing one note's judgement window
//   hit1        in   1  player 1 hit flag, sampled only with note_tick
//   hit2        in   1  player 2 hit flag, sampled only with note_tick
//   result1     out  5  player 1 score
//   result2     out  5  player 2 score
//   note_count  out  5  notes judged so far this round
//   busy        out  1  high while a round is being played
//   round_done  out  1  high once the round is complete; results are final
// -----------------------------------------------------------------------------
module score_keeper #(
    parameter int ROUND_NOTES = 20,
    parameter int MAX_SCORE   = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       note_tick,
    input  logic       hit1,
    input  logic       hit2,
    output logic [4:0] result1,
    output logic [4:0] result2,
    output logic [4:0] note_count,
    output logic       busy,
    output logic       round_done
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The count value seen on the tick that closes the round.
    localparam logic [4:0] LAST_NOTE = 5'(ROUND_NOTES - 1);

    // Ceiling compared against the 6-bit sum, so score + bonus cannot wrap.
    localparam logic [5:0] SCORE_CAP = 6'(MAX_SCORE);

    localparam logic [1:0] STREAK_BONUS = 2'd3;

    // Per-player state: the visible score plus the hidden streak counter.
    typedef struct packed {
        logic [4:0] score;
        logic [1:0] streak;
    } player_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] state_nxt;
    player_t    p1;
    player_t    p1_nxt;
    player_t    p2;
    player_t    p2_nxt;
    logic [4:0] count;
    logic [4:0] count_nxt;
    logic       busy_q;
    logic       busy_nxt;
    logic       done_q;
    logic       done_nxt;

    // -------------------------------------------------------------------------
    // Judge one player for one note. The fourth consecutive hit earns the bonus.
    // That hit also restarts the streak, so the bonus repeats every four hits.
    // -------------------------------------------------------------------------
    function automatic player_t judge(input player_t cur, input logic hit);
        player_t    nxt;
        logic [5:0] add;
        logic [5:0] sum;
        nxt = cur;
        if (hit) begin
            if (cur.streak == STREAK_BONUS) begin
                add        = 6'd2;
                nxt.streak = 2'd0;
            end else begin
                add        = 6'd1;
                nxt.streak = cur.streak + 2'd1;
            end
        end else begin
            add        = 6'd0;
            nxt.streak = 2'd0;
        end
        sum = {1'b0, cur.score} + add;
        if (sum > SCORE_CAP) begin
            nxt.score = SCORE_CAP[4:0];
        end else begin
            nxt.score = sum[4:0];
        end
        return nxt;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_nxt = state;
        p1_nxt    = p1;
        p2_nxt    = p2;
        count_nxt = count;

        case (state)
            IDLE, DONE: begin
                // A tick on the same edge as start belongs to no round.
                if (start) begin
                    state_nxt = PLAY;
                    p1_nxt    = '0;
                    p2_nxt    = '0;
                    count_nxt = '0;
                end
            end
            PLAY: begin
                // start is deliberately ignored while a round is running.
                if (note_tick) begin
                    p1_nxt    = judge(p1, hit1);
                    p2_nxt    = judge(p2, hit2);
                    count_nxt = count + 5'd1;
                    if (count == LAST_NOTE) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Status flags are decoded from the next state and then registered.
        // This keeps busy and round_done glitch-free flop outputs.
        busy_nxt = (state_nxt == PLAY);
        done_nxt = (state_nxt == DONE);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            p1     <= '0;
            p2     <= '0;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the
            // pre-edge values, independent of statement order.
            state  <= state_nxt;
            p1     <= p1_nxt;
            p2     <= p2_nxt;
            count  <= count_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, driven straight from flops
    // -------------------------------------------------------------------------
    assign result1    = p1.score;
    assign result2    = p2.score;
    assign note_count = count;
    assign busy       = busy_q;
    assign round_done = done_q;

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
//
// Drives three score_keeper instances from the same inputs. Each instance has
// different round length and ceiling parameters. A behavioural model derives
// the expected scores from hit run lengths: every fourth hit in an unbroken
// run earns the bonus. The bench walks directed scenarios first, then a block
// of random traffic.
// -----------------------------------------------------------------------------
module tb_score_keeper;

    typedef enum int { M_IDLE, M_PLAY, M_DONE } mstate_e;

    localparam int NDUT = 3;
    localparam int RN [NDUT] = '{20, 31, 7};
    localparam int MX [NDUT] = '{31, 31, 6};

    logic clk;
    logic reset;
    logic start;
    logic note_tick;
    logic hit1;
    logic hit2;

    logic [4:0] r1  [NDUT];
    logic [4:0] r2  [NDUT];
    logic [4:0] cnt [NDUT];
    logic       bsy [NDUT];
    logic       dn  [NDUT];

    int tests_run;
    int tests_failed;

    // Model state
    mstate_e m_st    [NDUT];
    int      m_score [NDUT][2];
    int      m_run   [NDUT][2];
    int      m_cnt   [NDUT];

    score_keeper #(.ROUND_NOTES(20), .MAX_SCORE(31)) u0 (
        .clk(clk), .reset(reset), .start(start), .note_tick(note_tick),
        .hit1(hit1), .hit2(hit2), .result1(r1[0]), .result2(r2[0]),
        .note_count(cnt[0]), .busy(bsy[0]), .round_done(dn[0])
    );

    score_keeper #(.ROUND_NOTES(31), .MAX_SCORE(31)) u1 (
        .clk(clk), .reset(reset), .start(start), .note_tick(note_tick),
        .hit1(hit1), .hit2(hit2), .result1(r1[1]), .result2(r2[1]),
        .note_count(cnt[1]), .busy(bsy[1]), .round_done(dn[1])
    );

    score_keeper #(.ROUND_NOTES(7), .MAX_SCORE(6)) u2 (
        .clk(clk), .reset(reset), .start(start), .note_tick(note_tick),
        .hit1(hit1), .hit2(hit2), .result1(r1[2]), .result2(r2[2]),
        .note_count(cnt[2]), .busy(bsy[2]), .round_done(dn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Comparison helper
    // -------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_st[k]  = M_IDLE;
            m_cnt[k] = 0;
            for (int p = 0; p < 2; p++) begin
                m_score[k][p] = 0;
                m_run[k][p]   = 0;
            end
        end
    endtask

    task automatic model_step(input logic s, input logic t, input logic a, input logic b);
        int  pts;
        logic h;
        for (int k = 0; k < NDUT; k++) begin
            if (m_st[k] == M_PLAY) begin
                if (t) begin
                    for (int p = 0; p < 2; p++) begin
                        h = (p == 0) ? a : b;
                        if (h) begin
                            m_run[k][p]++;
                            pts = (m_run[k][p] % 4 == 0) ? 2 : 1;
                        end else begin
                            m_run[k][p] = 0;
                            pts = 0;
                        end
                        m_score[k][p] = m_score[k][p] + pts;
                        if (m_score[k][p] > MX[k]) m_score[k][p] = MX[k];
                    end
                    m_cnt[k]++;
                    if (m_cnt[k] == RN[k]) m_st[k] = M_DONE;
                end
            end else if (s) begin
                m_st[k]  = M_PLAY;
                m_cnt[k] = 0;
                for (int p = 0; p < 2; p++) begin
                    m_score[k][p] = 0;
                    m_run[k][p]   = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("%s u%0d result1", tag, k), 32'(r1[k]), m_score[k][0]);
            chk($sformatf("%s u%0d result2", tag, k), 32'(r2[k]), m_score[k][1]);
            chk($sformatf("%s u%0d note_count", tag, k), 32'(cnt[k]), m_cnt[k]);
            chk($sformatf("%s u%0d busy", tag, k), 32'(bsy[k]), (m_st[k] == M_PLAY) ? 1 : 0);
            chk($sformatf("%s u%0d round_done", tag, k), 32'(dn[k]), (m_st[k] == M_DONE) ? 1 : 0);
        end
    endtask

    // Inputs are applied away from the edge; results are sampled 1 time unit after it.
    task automatic cycle(input string tag, input logic s, input logic t, input logic a, input logic b);
        start     = s;
        note_tick = t;
        hit1      = a;
        hit2      = b;
        @(posedge clk);
        model_step(s, t, a, b);
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges and check outputs before any edge arrives.
    // Then release reset on the falling edge.
    task automatic do_reset(input string tag);
        #2;
        start     = 1'b0;
        note_tick = 1'b0;
        hit1      = 1'b0;
        hit2      = 1'b0;
        reset     = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Directed and random stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [7:0] pat;
        logic       s;
        logic       t;

        tests_run    = 0;
        tests_failed = 0;
        start        = 1'b0;
        note_tick    = 1'b0;
        hit1         = 1'b0;
        hit2         = 1'b0;
        reset        = 1'b0;

        // Power-on reset, checked before the first clock edge.
        #1 reset = 1'b1;
        #2;
        model_reset();
        check_all("por");
        @(negedge clk);
        reset = 1'b0;

        // Ticks and hits in IDLE are ignored.
        repeat (3) cycle("idle_tick", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("idle note_count", 32'(cnt[0]), 0);

        // Full round: P1 hits every note, P2 misses every note.
        // The tick sharing the start edge is not counted.
        cycle("start", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("start tick not counted", 32'(cnt[0]), 0);
        chk("start busy", 32'(bsy[0]), 1);
        for (int i = 0; i < 20; i++) begin
            cycle("full_round", 1'b0, 1'b1, 1'b1, 1'b0);
            if (i == 18) chk("done low before last tick", 32'(dn[0]), 0);
        end
        chk("full result1", 32'(r1[0]), 25);
        chk("full result2", 32'(r2[0]), 0);
        chk("full note_count", 32'(cnt[0]), 20);
        chk("full round_done", 32'(dn[0]), 1);
        chk("full busy", 32'(bsy[0]), 0);
        chk("short round clamped", 32'(r1[2]), 6);

        // DONE ignores ticks and holds the results.
        cycle("done_hold", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("done hold result1", 32'(r1[0]), 25);
        chk("done hold note_count", 32'(cnt[0]), 20);

        // Restart from DONE. u1 is still in PLAY and ignores this start.
        cycle("restart", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart round_done", 32'(dn[0]), 0);
        chk("restart busy", 32'(bsy[0]), 1);
        chk("restart result1", 32'(r1[0]), 0);
        chk("restart result2", 32'(r2[0]), 0);

        // Streak break: H,H,H,M,H,H,H,H -> 3 + 0 + 1 + 1 + 1 + 2 = 8.
        pat = 8'b1111_0111;
        for (int i = 0; i < 8; i++) cycle("streak", 1'b0, 1'b1, pat[i], 1'b0);
        chk("streak result1", 32'(r1[0]), 8);
        // The bonus hit cleared the streak, so the next hit earns only 1.
        cycle("streak_after", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("streak cleared", 32'(r1[0]), 9);

        // Hits without a tick are ignored.
        cycle("hit_no_tick", 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("hit_no_tick", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("no tick result1", 32'(r1[0]), 9);
        chk("no tick note_count", 32'(cnt[0]), 9);

        // A start mid-PLAY is ignored: the count continues and scores are kept.
        do_reset("reset_a");
        cycle("midstart", 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle("midstart", 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        cycle("midstart_pulse", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("midstart count kept", 32'(cnt[0]), 5);
        cycle("midstart_next", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("midstart count 6", 32'(cnt[0]), 6);

        // Async reset mid-round after three P2 hits.
        do_reset("reset_b");
        cycle("p2_round", 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle("p2_hits", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("p2 result2", 32'(r2[0]), 3);
        do_reset("async_reset");
        chk("async result2", 32'(r2[0]), 0);
        chk("async busy", 32'(bsy[0]), 0);
        chk("async note_count", 32'(cnt[0]), 0);
        cycle("post_reset_start", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("post_reset_tick", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("new round result1", 32'(r1[0]), 1);
        chk("new round result2", 32'(r2[0]), 1);

        // Saturation: 31 straight hits give a raw score of 38, clamped to 31.
        do_reset("reset_c");
        cycle("sat_start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) cycle("saturate", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sat result1", 32'(r1[1]), 31);
        chk("sat note_count", 32'(cnt[1]), 31);
        chk("sat round_done", 32'(dn[1]), 1);
        chk("sat u0 result1", 32'(r1[0]), 25);

        // Random traffic, with occasional starts and resets.
        do_reset("reset_d");
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset("rand_reset");
            end else begin
                s = ($urandom_range(0, 24) == 0);
                t = ($urandom_range(0, 2) != 0);
                cycle("random", s, t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
